// File: rtl/xadc_drp_reader_pkg.sv
// Shared XADC DRP definitions: bus widths, auxiliary-channel addresses and
// the reader's state and sample-pair types.
package xadc_drp_package;

  localparam int XADC_DRP_DATA_WIDTH      = 16;
  localparam int XADC_DRP_AXIS_ADDR_WIDTH = 7;

  // Status-register addresses of VAUX4 (current) and VAUX12 (voltage)
  localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h14;
  localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h1C;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CURRENT,
    WAIT_VOLTAGE,
    PRESENT
  } xadc_drp_reader_state_t;

  typedef struct packed {
    logic [XADC_DRP_DATA_WIDTH-1:0] current;
    logic [XADC_DRP_DATA_WIDTH-1:0] voltage;
  } xadc_sample_pair_t;

endpackage

// File: rtl/xadc_drp_reader.sv
// DRP read master: on each XADC end-of-sequence reads vaux4 then vaux12 and
// presents the pair on a valid/ready stream. Define XADC_DRP_TIMEOUT_EN for the drdy timeout.
module xadc_drp_reader
  import xadc_drp_package::*;
#(
  parameter int OVERRUN_CNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                dclk_in,
  input  logic                                reset_n_in,
  input  logic                                eos_in,
  output logic                                den_out,
  output logic                                dwe_out,
  output logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] daddr_out,
  output logic [XADC_DRP_DATA_WIDTH-1:0]      di_out,
  input  logic                                drdy_in,
  input  logic [XADC_DRP_DATA_WIDTH-1:0]      do_in,
  output logic [XADC_DRP_DATA_WIDTH-1:0]      sample_current_out,
  output logic [XADC_DRP_DATA_WIDTH-1:0]      sample_voltage_out,
  output logic                                sample_valid_out,
  input  logic                                sample_ready_in,
  output logic [OVERRUN_CNT_WIDTH-1:0]        overrun_count_out,
  output logic                                timeout_error_out
);

  if (TIMEOUT_CYCLES < 1 || OVERRUN_CNT_WIDTH < 1) begin : g_param_chk
    $error("xadc_drp_reader: TIMEOUT_CYCLES and OVERRUN_CNT_WIDTH must be >= 1");
  end

  xadc_drp_reader_state_t                state_q;
  logic                                  den_q;
  logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0]   daddr_q;
  xadc_sample_pair_t                     pair_q;
  logic                                  valid_q;
  logic                                  timeout_q;
  logic [OVERRUN_CNT_WIDTH-1:0]          overrun_q, overrun_d;

  logic in_wait;
  logic drdy_acc;
  logic eos_drop;
  logic timeout_hit;

  // drdy is only honoured once the den pulse of the pending read has ended
  assign in_wait  = (state_q == WAIT_CURRENT) || (state_q == WAIT_VOLTAGE);
  assign drdy_acc = drdy_in && !den_q;
  assign eos_drop = eos_in && (in_wait || ((state_q == PRESENT) && !sample_ready_in));

  always_comb begin
    overrun_d = overrun_q;
    if (eos_drop && (overrun_q != '1)) overrun_d = overrun_q + 1'b1;
  end

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;

  // Leaving a wait state (or being outside one) restarts the count at zero
  always_comb begin
    timer_d = '0;
    if (in_wait && !drdy_acc) timer_d = timer_q + 1'b1;
  end

  assign timeout_hit = in_wait && !drdy_acc && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) timer_q <= '0;
    else             timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= IDLE;
      den_q     <= 1'b0;
      daddr_q   <= '0;
      pair_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= '0;
    end else begin
      den_q     <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (eos_in) begin
            den_q   <= 1'b1;
            daddr_q <= XADC_DRP_ADDR_CURRENT_CHANNEL;
            state_q <= WAIT_CURRENT;
          end
        end
        WAIT_CURRENT: begin
          if (drdy_acc) begin
            pair_q.current <= do_in;
            den_q          <= 1'b1;
            daddr_q        <= XADC_DRP_ADDR_VOLTAGE_CHANNEL;
            state_q        <= WAIT_VOLTAGE;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WAIT_VOLTAGE: begin
          if (drdy_acc) begin
            pair_q.voltage <= do_in;
            valid_q        <= 1'b1;
            state_q        <= PRESENT;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        PRESENT: begin
          if (sample_ready_in) begin
            valid_q <= 1'b0;
            if (eos_in) begin
              den_q   <= 1'b1;
              daddr_q <= XADC_DRP_ADDR_CURRENT_CHANNEL;
              state_q <= WAIT_CURRENT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign den_out            = den_q;
  assign dwe_out            = 1'b0;
  assign di_out             = '0;
  assign daddr_out          = daddr_q;
  assign sample_current_out = pair_q.current;
  assign sample_voltage_out = pair_q.voltage;
  assign sample_valid_out   = valid_q;
  assign overrun_count_out  = overrun_q;
  assign timeout_error_out  = timeout_q;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Self-checking bench for xadc_drp_reader with a behavioural DRP slave model.
module tb_xadc_drp_reader;

  localparam logic [6:0] A_CUR  = 7'h14;
  localparam logic [6:0] A_VOLT = 7'h1C;
  localparam int         TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eos = 1'b0;
  logic        den, dwe, valid, tmo;
  logic        drdy = 1'b0;
  logic        ready = 1'b0;
  logic [6:0]  daddr;
  logic [15:0] di, scur, svolt;
  logic [15:0] dout = 16'h0;
  logic [7:0]  ovr;

  int          checks = 0;
  int          errors = 0;
  int          exp_ovr = 0;

  int          lat_cfg = 3;
  int          cd = 0;
  logic [15:0] cur_val = 16'h0;
  logic [15:0] volt_val = 16'h0;
  logic [6:0]  addr_lat = 7'h0;
  bit          drdy_en = 1'b1;
  bit          manual_drdy = 1'b0;

  xadc_drp_reader #(.OVERRUN_CNT_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .dclk_in(clk), .reset_n_in(rst_n), .eos_in(eos),
    .den_out(den), .dwe_out(dwe), .daddr_out(daddr), .di_out(di),
    .drdy_in(drdy), .do_in(dout),
    .sample_current_out(scur), .sample_voltage_out(svolt),
    .sample_valid_out(valid), .sample_ready_in(ready),
    .overrun_count_out(ovr), .timeout_error_out(tmo)
  );

  always #5 clk = ~clk;

  // DRP slave: answers each den with drdy exactly lat_cfg cycles later
  always @(posedge clk) begin
    #1;
    drdy = 1'b0;
    dout = 16'($urandom);
    if (cd > 0) begin
      cd--;
      if (cd == 0 && drdy_en) begin
        drdy = 1'b1;
        dout = (addr_lat == A_CUR) ? cur_val : (addr_lat == A_VOLT) ? volt_val : 16'hDEAD;
      end
    end
    if (manual_drdy) begin
      drdy = 1'b1;
      dout = 16'hBEEF;
    end
    if (den) begin
      cd = lat_cfg;
      addr_lat = daddr;
    end
  end

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse EOS and wait for valid; lat counts cycles after the EOS cycle, -1 on timeout
  task automatic run_read(input int l, input logic [15:0] c, input logic [15:0] v, output int lat);
    lat_cfg = l; cur_val = c; volt_val = v; drdy_en = 1'b1;
    eos = 1'b1; tick(); eos = 1'b0;
    lat = 1;
    while (!valid && lat < 200) begin tick(); lat++; end
    if (!valid) lat = -1;
  endtask

  task automatic handshake();
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if ({den, dwe, valid, tmo} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {den, dwe, valid, tmo}); end
    checks++; if (daddr !== 7'h0) begin errors++; $display("FAIL reset_daddr got %h want 00", daddr); end
    checks++; if (di !== 16'h0) begin errors++; $display("FAIL reset_di got %h want 0000", di); end
    checks++; if ({scur, svolt} !== 32'h0) begin errors++; $display("FAIL reset_samples got %h/%h want 0/0", scur, svolt); end
    checks++; if (ovr !== 8'h0) begin errors++; $display("FAIL reset_ovr got %0d want 0", ovr); end
    rst_n = 1'b1;
    tick();
    exp_ovr = 0;
  endtask

  task automatic test_latency();
    lat_cfg = 3; cur_val = 16'd127; volt_val = 16'd255;
    eos = 1'b1; tick(); eos = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      checks++; if (den !== ((k == 1) || (k == 5))) begin errors++; $display("FAIL lat_den cyc %0d got %b want %b", k, den, (k == 1) || (k == 5)); end
      if (k == 1) begin checks++; if (daddr !== A_CUR) begin errors++; $display("FAIL lat_addr_cur got %h want %h", daddr, A_CUR); end end
      if (k == 5) begin checks++; if (daddr !== A_VOLT) begin errors++; $display("FAIL lat_addr_volt got %h want %h", daddr, A_VOLT); end end
      checks++; if (valid !== (k >= 9)) begin errors++; $display("FAIL lat_valid cyc %0d got %b want %b", k, valid, k >= 9); end
      if (k < 12) tick();
    end
    checks++; if ({scur, svolt} !== {16'd127, 16'd255}) begin errors++; $display("FAIL lat_pair got %0d/%0d want 127/255", scur, svolt); end
    checks++; if (dwe !== 1'b0 || di !== 16'h0) begin errors++; $display("FAIL lat_write got %b/%h want 0/0", dwe, di); end
  endtask

  // Continues from test_latency with the pair still presented
  task automatic test_overrun_hold();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      eos = (i == 3) || (i == 8) || (i == 13);
      tick();
      if (!valid || scur !== 16'd127 || svolt !== 16'd255) bad++;
    end
    eos = 1'b0;
    exp_ovr = sat(exp_ovr + 3);
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    checks++; if (ovr !== 8'(exp_ovr)) begin errors++; $display("FAIL hold_ovr got %0d want %0d", ovr, exp_ovr); end
    handshake();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", valid); end
  endtask

  task automatic test_random_pairs();
    int l, lat, d;
    logic [15:0] c, v;
    for (int n = 0; n < 8; n++) begin
      l = $urandom_range(1, 6); c = 16'($urandom); v = 16'($urandom);
      run_read(l, c, v, lat);
      checks++; if (lat != 2 * l + 3) begin errors++; $display("FAIL rand_lat L=%0d got %0d want %0d", l, lat, 2 * l + 3); end
      checks++; if ({scur, svolt} !== {c, v}) begin errors++; $display("FAIL rand_pair got %h/%h want %h/%h", scur, svolt, c, v); end
      d = $urandom_range(0, 3);
      repeat (d) tick();
      checks++; if (valid !== 1'b1 || {scur, svolt} !== {c, v}) begin errors++; $display("FAIL rand_stable got %b %h/%h want 1 %h/%h", valid, scur, svolt, c, v); end
      handshake();
      checks++; if (valid !== 1'b0 || ovr !== 8'(exp_ovr)) begin errors++; $display("FAIL rand_done got %b ovr %0d want 0 ovr %0d", valid, ovr, exp_ovr); end
    end
  endtask

  task automatic test_eos_handshake();
    int lat;
    logic [15:0] c2, v2;
    run_read(2, 16'h1111, 16'h2222, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL b2b_first got %0d want 7", lat); end
    c2 = 16'($urandom); v2 = 16'($urandom);
    cur_val = c2; volt_val = v2;
    ready = 1'b1; eos = 1'b1; tick(); ready = 1'b0; eos = 1'b0;
    checks++; if (den !== 1'b1 || daddr !== A_CUR) begin errors++; $display("FAIL b2b_den got %b/%h want 1/%h", den, daddr, A_CUR); end
    checks++; if (valid !== 1'b0 || ovr !== 8'(exp_ovr)) begin errors++; $display("FAIL b2b_state got %b ovr %0d want 0 ovr %0d", valid, ovr, exp_ovr); end
    lat = 1;
    while (!valid && lat < 200) begin tick(); lat++; end
    checks++; if (lat != 2 * 2 + 3 || {scur, svolt} !== {c2, v2}) begin errors++; $display("FAIL b2b_second got lat %0d %h/%h want 7 %h/%h", lat, scur, svolt, c2, v2); end
    handshake();
  endtask

  task automatic test_saturation();
    int lat;
    run_read(1, 16'h0ABC, 16'h0DEF, lat);
    eos = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) begin checks++; if (ovr !== 8'(sat(exp_ovr + 100))) begin errors++; $display("FAIL sat_mid got %0d want %0d", ovr, sat(exp_ovr + 100)); end end
    end
    eos = 1'b0;
    exp_ovr = sat(exp_ovr + 300);
    checks++; if (ovr !== 8'(exp_ovr)) begin errors++; $display("FAIL sat_final got %0d want %0d", ovr, exp_ovr); end
    checks++; if ({scur, svolt} !== {16'h0ABC, 16'h0DEF}) begin errors++; $display("FAIL sat_pair got %h/%h want 0abc/0def", scur, svolt); end
    handshake();
  endtask

  task automatic test_reset_mid_read();
    int k = 0, lat, bad = 0;
    lat_cfg = 3; cur_val = 16'h5555; volt_val = 16'h6666;
    eos = 1'b1; tick(); eos = 1'b0;
    while (!(den && daddr == A_VOLT) && k < 50) begin tick(); k++; end
    checks++; if (!(den && daddr == A_VOLT)) begin errors++; $display("FAIL rstmid_reach got %b/%h want 1/%h", den, daddr, A_VOLT); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({den, valid, tmo, daddr, scur, svolt, ovr} !== '0) begin errors++; $display("FAIL rstmid_async got den %b addr %h cur %h volt %h ovr %0d want all 0", den, daddr, scur, svolt, ovr); end
    tick(); tick();
    rst_n = 1'b1;
    exp_ovr = 0;
    tick();
    manual_drdy = 1'b1; tick(); manual_drdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (den || valid || scur !== 16'h0 || svolt !== 16'h0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_late_drdy got %0d disturbed cycles want 0", bad); end
    run_read(3, 16'h1234, 16'h5678, lat);
    checks++; if (lat != 9 || {scur, svolt} !== {16'h1234, 16'h5678}) begin errors++; $display("FAIL rstmid_fresh got lat %0d %h/%h want 9 1234/5678", lat, scur, svolt); end
    checks++; if (ovr !== 8'(exp_ovr)) begin errors++; $display("FAIL rstmid_ovr got %0d want %0d", ovr, exp_ovr); end
    handshake();
  endtask

  task automatic test_timeout();
    int k, lat;
    bit seen_valid = 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
    drdy_en = 1'b0;
    eos = 1'b1; tick(); eos = 1'b0;
    k = 1;
    while (!tmo && k < 200) begin if (valid) seen_valid = 1'b1; tick(); k++; end
    checks++; if (k - 1 != TMO) begin errors++; $display("FAIL tmo_delay got %0d want %0d", k - 1, TMO); end
    tick();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_width got %b want 0", tmo); end
    checks++; if (seen_valid || valid) begin errors++; $display("FAIL tmo_valid got 1 want 0"); end
    run_read(2, 16'h7777, 16'h8888, lat);
    checks++; if (lat != 7 || {scur, svolt} !== {16'h7777, 16'h8888}) begin errors++; $display("FAIL tmo_recover got lat %0d %h/%h want 7 7777/8888", lat, scur, svolt); end
    handshake();
`else
    int pulses = 0;
    drdy_en = 1'b0;
    eos = 1'b1; tick(); eos = 1'b0;
    for (k = 0; k < 150; k++) begin
      if (tmo) pulses++;
      if (valid) seen_valid = 1'b1;
      tick();
    end
    checks++; if (pulses != 0 || seen_valid) begin errors++; $display("FAIL notmo_wait got %0d pulses valid %b want 0 0", pulses, seen_valid); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    exp_ovr = 0;
    run_read(2, 16'h7777, 16'h8888, lat);
    checks++; if (lat != 7 || {scur, svolt} !== {16'h7777, 16'h8888}) begin errors++; $display("FAIL notmo_recover got lat %0d %h/%h want 7 7777/8888", lat, scur, svolt); end
    handshake();
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_overrun_hold();
    test_random_pairs();
    test_eos_handshake();
    test_saturation();
    test_reset_mid_read();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
